// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - byte FIFO feeding an 8N1 UART transmitter
module uart_tx_buf #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr_en,
    input  logic [7:0]                    i_wr_data,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_busy,
    output logic                          o_uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [15:0]     r_baud;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            w_full;
    logic            w_nonempty;
    logic            w_push;
    logic            w_pop;
    logic            w_bit_end;

    // Fullness is judged from the level count, so equal pointers are never ambiguous.
    assign w_full     = (r_level == LW'(FIFO_DEPTH));
    assign w_nonempty = (r_level != '0);
    assign w_push     = i_wr_en && !w_full;
    assign w_bit_end  = (r_baud == 16'd0);

    assign o_full    = w_full;
    assign o_level   = r_level;
    assign o_busy    = (r_state != S_IDLE) || w_nonempty;
    assign o_uart_tx = r_tx;

    // Next-state logic; a pop happens whenever a new frame is launched.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // FIFO pointers and level; a dropped write leaves all of them untouched.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Baud timing, shift register and the registered serial line.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_baud    <= '0;
            r_bit_idx <= '0;
        end else if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_tx      <= 1'b0;
            r_baud    <= BAUD_RELOAD;
            r_bit_idx <= '0;
        end else if (r_state != S_IDLE) begin
            if (!w_bit_end) begin
                r_baud <= r_baud - 16'd1;
            end else begin
                case (r_state)
                    S_START: begin
                        r_tx   <= r_shift[0];
                        r_baud <= BAUD_RELOAD;
                    end
                    S_DATA: begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_tx <= 1'b1;
                        end else begin
                            r_tx      <= r_shift[1];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                    S_STOP: begin
                        r_tx   <= 1'b1;
                        r_baud <= '0;
                    end
                    default: r_tx <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - scoreboard bench for uart_tx_buf
module tb_uart_tx_buf;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic [2:0] level;
    logic       busy;
    logic       uart_tx;

    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         start_times[$];
    int         mon_frames = 0;
    bit         mon_active = 0;
    int         mon_cnt = 0;
    int         mon_bad = 0;
    logic [7:0] mon_bits;
    logic [7:0] mon_exp;
    int         w_n;
    int         errs;

    uart_tx_buf #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .o_full    (full),
        .o_level   (level),
        .o_busy    (busy),
        .o_uart_tx (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, want);
    endtask

    // Line monitor: decodes each 40-cycle frame sample by sample and scores it.
    always @(negedge clk) begin
        if (!rst) begin
            mon_active = 0;
            mon_cnt    = 0;
        end else if (!mon_active) begin
            if (uart_tx === 1'b0) begin
                mon_active = 1;
                mon_cnt    = 1;
                mon_bad    = 0;
                mon_bits   = 8'h00;
                start_times.push_back(cyc);
            end
        end else begin
            if (mon_cnt < 4) begin
                if (uart_tx !== 1'b0) mon_bad++;
            end else if (mon_cnt < 36) begin
                if (mon_cnt % 4 == 0) mon_bits[mon_cnt/4 - 1] = uart_tx;
                else if (uart_tx !== mon_bits[mon_cnt/4 - 1]) mon_bad++;
            end else begin
                if (uart_tx !== 1'b1) mon_bad++;
            end
            mon_cnt++;
            if (mon_cnt == 40) begin
                mon_active = 0;
                mon_frames++;
                check("frame_timing", mon_bad, 0);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL frame_unexpected: got %02h required none", mon_bits);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("frame_data", {24'd0, mon_bits}, {24'd0, mon_exp});
                end
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active || busy) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, (n < limit), 1);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        #1 rst = 1'b0;
        #1;
        check("rst_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Quiet line after reset
        errs = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (uart_tx !== 1'b1 || busy !== 1'b0 || level !== 3'd0) errs++;
        end
        check("idle_quiet", errs, 0);

        // Single byte 0xA5 with exact latency
        start_times.delete();
        mon_frames = 0;
        exp_q.push_back(8'hA5);
        write_byte(8'hA5);
        w_n = cyc;
        check("single_level_after_wr", level, 1);
        check("single_busy_after_wr", busy, 1);
        check("single_tx_before_start", uart_tx, 1);
        wait_edges(1);
        check("single_start_bit", uart_tx, 0);
        check("single_level_popped", level, 0);
        wait_edges(39);
        check("single_busy_in_stop", busy, 1);
        check("single_stop_bit", uart_tx, 1);
        wait_edges(1);
        check("single_busy_dropped", busy, 0);
        drain("single_drain", 20);
        check("single_start_count", start_times.size(), 1);
        if (start_times.size() > 0) check("single_start_cycle", start_times[0], w_n + 1);

        // Back-to-back frames with no idle gap
        start_times.delete();
        mon_frames = 0;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0F);
        wr_en = 1'b1;
        wr_data = 8'h55;
        @(posedge clk);
        #1 wr_data = 8'h0F;
        @(posedge clk);
        #1 wr_en = 1'b0;
        drain("b2b_drain", 120);
        check("b2b_frames", mon_frames, 2);
        if (start_times.size() == 2) check("b2b_gap", start_times[1] - start_times[0], 40);

        // Overflow: sixth write is dropped
        mon_frames = 0;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        wr_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            wr_data = 8'(i);
            @(posedge clk);
            #1;
            if (i == 5) begin
                check("ovf_full_at_5", full, 1);
                check("ovf_level_at_5", level, 4);
            end
        end
        wr_en = 1'b0;
        check("ovf_level_after_drop", level, 4);
        check("ovf_full_after_drop", full, 1);
        drain("ovf_drain", 300);
        check("ovf_frames", mon_frames, 5);

        // Write on the STOP->START pop edge while full
        mon_frames = 0;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            wr_data = 8'hA0 + 8'(i);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        wait_edges(36);
        check("simul_full_before", full, 1);
        check("simul_level_before", level, 4);
        write_byte(8'h77);
        check("simul_level_after", level, 3);
        check("simul_full_after", full, 0);
        check("simul_next_start", uart_tx, 0);
        drain("simul_drain", 300);
        check("simul_frames", mon_frames, 5);

        // Reset in the middle of a frame
        wr_en = 1'b1;
        wr_data = 8'hFF;
        @(posedge clk);
        #1 wr_data = 8'h12;
        @(posedge clk);
        #1 wr_en = 1'b0;
        check("midrst_level_queued", level, 1);
        wait_edges(9);
        #1 rst = 1'b0;
        #1;
        check("midrst_tx", uart_tx, 1);
        check("midrst_level", level, 0);
        check("midrst_full", full, 0);
        check("midrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        mon_frames = 0;
        exp_q.push_back(8'h3C);
        write_byte(8'h3C);
        check("midrst_first_write", level, 1);
        drain("midrst_drain", 100);
        check("midrst_frames", mon_frames, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
